// File: rtl/seqdet_serializer.sv
// ---------------------------------------------------------------------------
// seqdet_serializer
//
// Parallel-to-serial front end for the 1101 sequence detectors. WIDTH-bit
// words arrive over a valid/ready handshake and leave one bit per enabled
// clock on o_bit, qualified by o_bit_valid. Consecutive words stream with no
// gap cycle between them.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   i_valid      input word valid
//   i_data       input word, captured only on a handshake
//   o_ready      serializer can accept a word this cycle
//   i_en         bit strobe; one bit advances per cycle with i_en=1
//   o_bit        current serial bit
//   o_bit_valid  o_bit is consumed this cycle (busy && i_en)
//   o_busy       a word is in flight
//
// Build option:
//   SER_PARITY_EN  when defined, each word is followed by one even-parity bit
//                  (XOR of the captured word) sent from an extra PAR state.
// ---------------------------------------------------------------------------
module seqdet_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  input  logic             i_en,
  output logic             o_bit,
  output logic             o_bit_valid,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             ready;
  logic             bitOut;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // The outgoing bit always sits at one end of the register, so advancing
  // means shifting toward that end and filling the other end with zero.
  assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shift_q[WIDTH-1:1]};

  // State register; reset abandons any word in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
`ifdef SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state and output logic. o_ready is raised in the cycle whose edge
  // retires the final bit of the current word, so a waiting word loads on
  // that same edge and its first bit follows with no gap. o_ready never
  // looks at i_valid, which keeps the handshake free of combinational loops.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
`ifdef SER_PARITY_EN
    parity_d = parity_q;
`endif
    ready    = 1'b0;
    bitOut   = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
      end
      SHIFT: begin
        bitOut = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
        if (i_en) begin
          shift_d = shifted;
          if (cnt_q == LAST_CNT) begin
`ifdef SER_PARITY_EN
            state_d = PAR;
            cnt_d   = cnt_q + CW'(1);
`else
            ready   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef SER_PARITY_EN
      PAR: begin
        bitOut = parity_q;
        if (i_en) begin
          ready   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // A handshake overrides whatever the word-end path chose above.
    if (i_valid && ready) begin
      state_d  = SHIFT;
      shift_d  = i_data;
      cnt_d    = '0;
`ifdef SER_PARITY_EN
      parity_d = ^i_data;
`endif
    end
  end

  assign o_ready     = ready;
  assign o_bit       = bitOut;
  assign o_busy      = (state_q != IDLE);
  assign o_bit_valid = o_busy && i_en;

endmodule
